i2s_xmit: RTL and testbench

- I2S serial transmitter. Feeds the DAC path with processed stereo samples, mirroring the receive path.
- Runs entirely on `mck` and takes `bck`/`lrck` from the clock divider as ordinary inputs. It detects their edges in the `mck` domain.
- Accepts one stereo 24-bit sample pair per frame over a valid/ready handshake and shifts it out MSB-first in standard I2S format (1-bck delay after `lrck` edge, left channel while `lrck`=0).

---
 rtl/i2s_xmit.sv | 98 +++++++++
 tb/tb_i2s_xmit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_xmit.sv
// I2S serial transmitter: takes one stereo pair per frame over valid/ready and shifts it out
// MSB-first, one bck after each lrck edge. bck/lrck arrive as plain inputs and are edge-detected on mck.
module i2s_xmit #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned SLOT_MAX = 32
) (
  input  logic             mck,
  input  logic             reset,
  input  logic             bck,
  input  logic             lrck,
  input  logic [WIDTH-1:0] data_l,
  input  logic [WIDTH-1:0] data_r,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sdout,
  output logic             underrun
);

  localparam int unsigned     CntW     = $clog2(SLOT_MAX) + 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SLOT_MAX - 1);
  localparam logic [CntW-1:0] CntWidth = CntW'(WIDTH);

  logic             bck_d1, bck_d2, lrck_d1, lrck_last;
  logic             full, primed;
  logic [WIDTH-1:0] buf_l, buf_r, shift, shadow_r;
  logic [CntW-1:0]  bitcnt;

  logic bck_fall, slot_start, left_start, accept, full_next;

  always_comb begin
    bck_fall   = bck_d2 & ~bck_d1;
    slot_start = bck_fall & (lrck_d1 != lrck_last);
    left_start = slot_start & ~lrck_d1;
    accept     = data_valid & data_ready;
    // A left start consumes the buffer before a same-cycle handshake refills it.
    full_next  = (full & ~left_start) | accept;
  end

  always_ff @(posedge mck) begin
    if (reset) begin
      // Edge detectors track the live inputs so no phantom edge appears on release.
      bck_d1     <= bck;
      bck_d2     <= bck;
      lrck_d1    <= lrck;
      lrck_last  <= lrck;
      full       <= 1'b0;
      primed     <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      shift      <= '0;
      shadow_r   <= '0;
      bitcnt     <= '0;
      sdout      <= 1'b0;
      underrun   <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      bck_d1     <= bck;
      bck_d2     <= bck_d1;
      lrck_d1    <= lrck;
      underrun   <= 1'b0;
      full       <= full_next;
      data_ready <= ~full_next;

      if (accept) begin
        buf_l  <= data_l;
        buf_r  <= data_r;
        primed <= 1'b1;
      end

      if (slot_start) begin
        lrck_last <= lrck_d1;
        bitcnt    <= '0;
        sdout     <= 1'b0;
        if (!lrck_d1) begin
          if (full) begin
            shift    <= buf_l;
            shadow_r <= buf_r;
          end else begin
            shift    <= '0;
            shadow_r <= '0;
            underrun <= primed;
          end
        end else begin
          shift <= shadow_r;
        end
      end else if (bck_fall) begin
        if (bitcnt < CntWidth) begin
          sdout <= shift[WIDTH-1];
          shift <= shift << 1;
        end else begin
          sdout <= 1'b0;
        end
        if (bitcnt != CntMax) bitcnt <= bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_xmit.sv
// Bench for i2s_xmit: directed steps plus random pairs, checked against a slot-level model
// that predicts every transmitted bit, underrun pulse and ready level from the frame timing.
module tb_i2s_xmit;

  localparam int unsigned WIDTH = 24;

  logic             mck = 1'b0;
  logic             reset = 1'b1;
  logic [9:0]       cnt = '0;
  logic             jump = 1'b0;
  logic             bck, lrck;
  logic [WIDTH-1:0] data_l = '0;
  logic [WIDTH-1:0] data_r = '0;
  logic             data_valid = 1'b0;
  logic             data_ready, sdout, underrun;

  int   vecs = 0;
  int   errs = 0;
  int   und_cnt = 0;
  int   und0;
  logic done = 1'b0;

  logic             armed = 1'b0;
  logic             m_full, m_primed, exp_und, exp_rdy, ls, hs;
  logic [WIDTH-1:0] m_l, m_r, cur_l, cur_r;

  logic [WIDTH-1:0] w, base, pl, pr;
  logic             dly;
  logic [6:0]       tail;

  i2s_xmit #(
    .WIDTH    (WIDTH),
    .SLOT_MAX (32)
  ) dut (
    .mck        (mck),
    .reset      (reset),
    .bck        (bck),
    .lrck       (lrck),
    .data_l     (data_l),
    .data_r     (data_r),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sdout      (sdout),
    .underrun   (underrun)
  );

  always #5 mck = ~mck;

  // Divider: bck = mck/16, lrck = mck/1024; jump forces an early lrck toggle on a bck fall.
  always @(posedge mck)
    cnt <= (jump && cnt[3:0] == 4'hf) ? {~cnt[9], 9'd0} : cnt + 10'd1;
  assign bck  = cnt[3];
  assign lrck = cnt[9];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [WIDTH-1:0] word, input int p);
    if (p >= 1 && p <= int'(WIDTH)) return word[int'(WIDTH) - p];
    return 1'b0;
  endfunction

  task automatic wait_cnt(input logic [9:0] target);
    int n = 0;
    do begin
      @(negedge mck);
      n++;
    end while (cnt != target && n < 2100);
    if (cnt != target) check("wait_cnt timeout", 32'(cnt), 32'(target));
  endtask

  task automatic capture_slot(input logic lr, output logic [WIDTH-1:0] word,
                              output logic delay_bit, output logic [6:0] tail_bits);
    wait_cnt({lr, 9'd0});
    word = '0;
    tail_bits = '0;
    delay_bit = 1'b0;
    for (int p = 0; p < 32; p++) begin
      wait_cnt({lr, 5'(p), 4'd8});
      if (p == 0) delay_bit = sdout;
      else if (p <= int'(WIDTH)) word = {word[WIDTH-2:0], sdout};
      else tail_bits = {tail_bits[5:0], sdout};
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    int n = 0;
    @(negedge mck);
    data_l = l;
    data_r = r;
    data_valid = 1'b1;
    while (!data_ready && n < 4096) begin
      @(negedge mck);
      n++;
    end
    if (!data_ready) check("send timeout", 32'(data_ready), 32'd1);
    @(posedge mck);
    #1;
    data_valid = 1'b0;
  endtask

  initial begin
    fork
      begin : model
        while (!done) begin
          @(negedge mck);
          #1;
          if (armed) begin
            if (underrun) und_cnt++;
            check("underrun", 32'(underrun), 32'(exp_und));
            check("data_ready", 32'(data_ready), 32'(exp_rdy));
            if (cnt[3:0] == 4'd8)
              check("sdout", 32'(sdout), 32'(exp_bit(cnt[9] ? cur_r : cur_l, int'(cnt[8:4]))));
          end
          // Predict the effect of the coming mck edge.
          if (reset) begin
            m_full   = 1'b0;
            m_primed = 1'b0;
            cur_l    = '0;
            cur_r    = '0;
            exp_und  = 1'b0;
            exp_rdy  = 1'b0;
            armed    = 1'b1;
          end else if (armed) begin
            ls      = (cnt[8:0] == 9'd1) && !cnt[9];
            hs      = data_valid && !m_full;
            exp_und = ls && !m_full && m_primed;
            if (ls) begin
              cur_l  = m_full ? m_l : '0;
              cur_r  = m_full ? m_r : '0;
              m_full = 1'b0;
            end
            if (hs) begin
              m_l      = data_l;
              m_r      = data_r;
              m_full   = 1'b1;
              m_primed = 1'b1;
            end
            exp_rdy = !m_full;
          end
        end
      end

      begin : stim
        // Reset state.
        repeat (3) @(negedge mck);
        check("reset sdout", 32'(sdout), 32'd0);
        check("reset underrun", 32'(underrun), 32'd0);
        check("reset data_ready", 32'(data_ready), 32'd0);
        wait_cnt(10'd20);
        reset = 1'b0;
        @(posedge mck);
        #1;
        check("ready after reset", 32'(data_ready), 32'd1);

        // Idle frames: not primed, so no underrun.
        repeat (4) wait_cnt(10'd100);
        check("idle underrun count", 32'(und_cnt), 32'd0);

        // Known pattern.
        send(24'hA5A5A5, 24'h3C3C3C);
        capture_slot(1'b0, w, dly, tail);
        check("L delay bit", 32'(dly), 32'd0);
        check("L word", 32'(w), 32'h00A5A5A5);
        check("L tail", 32'(tail), 32'd0);
        capture_slot(1'b1, w, dly, tail);
        check("R delay bit", 32'(dly), 32'd0);
        check("R word", 32'(w), 32'h003C3C3C);
        check("R tail", 32'(tail), 32'd0);

        // Stall: zero frame and one underrun.
        und0 = und_cnt;
        capture_slot(1'b0, w, dly, tail);
        check("stall L word", 32'(w), 32'd0);
        check("stall underrun", 32'(und_cnt), 32'(und0 + 1));

        // Continuous stream L=n, R=~n.
        und0 = und_cnt;
        base = 24'($urandom);
        for (int i = 0; i < 8; i++) send(base + 24'(i), ~(base + 24'(i)));
        capture_slot(1'b0, w, dly, tail);
        check("stream last L", 32'(w), 32'(base + 24'd7));
        check("stream underrun", 32'(und_cnt), 32'(und0));

        // Handshake coinciding with a left start on an empty buffer.
        und0 = und_cnt;
        pl = 24'($urandom);
        pr = 24'($urandom);
        wait_cnt(10'd1);
        data_l = pl;
        data_r = pr;
        data_valid = 1'b1;
        @(posedge mck);
        #1;
        data_valid = 1'b0;
        capture_slot(1'b0, w, dly, tail);
        check("coincide next L", 32'(w), 32'(pl));
        check("coincide underrun", 32'(und_cnt), 32'(und0 + 1));
        capture_slot(1'b1, w, dly, tail);
        check("coincide next R", 32'(w), 32'(pr));

        // Short left slot: lrck toggles after 10 bck.
        pl = 24'($urandom);
        pr = 24'($urandom);
        send(pl, pr);
        wait_cnt(10'd0);
        wait_cnt({1'b0, 5'd9, 4'hf});
        jump = 1'b1;
        @(posedge mck);
        #1;
        jump = 1'b0;
        capture_slot(1'b1, w, dly, tail);
        check("short R delay", 32'(dly), 32'd0);
        check("short R word", 32'(w), 32'(pr));
        check("short R tail", 32'(tail), 32'd0);

        // Reset during bit 12 of a left word; bit 12 forced high so the abort is visible.
        pl = 24'($urandom) | 24'h001000;
        pr = 24'($urandom);
        send(pl, pr);
        wait_cnt(10'd0);
        wait_cnt({1'b0, 5'd12, 4'd5});
        reset = 1'b1;
        @(posedge mck);
        #1;
        check("mid reset sdout", 32'(sdout), 32'd0);
        check("mid reset ready", 32'(data_ready), 32'd0);
        @(negedge mck);
        reset = 1'b0;
        @(posedge mck);
        #1;
        check("ready after mid reset", 32'(data_ready), 32'd1);
        und0 = und_cnt;
        capture_slot(1'b1, w, dly, tail);
        check("R after reset", 32'(w), 32'd0);
        wait_cnt(10'd100);
        check("unprimed underrun", 32'(und_cnt), 32'(und0));

        // Random pairs with random gaps.
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(0, 400)) @(negedge mck);
          send(24'($urandom), 24'($urandom));
        end
        repeat (3) wait_cnt(10'd100);

        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
